// File: rtl/pytxacl_ringbuf_ctrl_pkg.sv
// Shared defaults and bank-role selection for the ACL TX payload ring buffer.
package pytxacl_pkg;

  localparam int DEF_DW    = 32;
  localparam int DEF_AW    = 8;
  localparam int DEF_NBANK = 4;
  localparam int DEF_LW    = 10;
  localparam int DEF_PTRW  = $clog2(DEF_NBANK);

  typedef enum logic [1:0] {
    BANK_IDLE = 2'd0,
    BANK_WR   = 2'd1,
    BANK_RD   = 2'd2
  } bank_role_e;

  // The read side wins when the pointers meet on a full ring; when the ring is
  // empty the same bank is handed to the writer instead.
  function automatic bank_role_e bank_sel(input int bank, input int wr_ptr,
                                          input int rd_ptr, input logic full,
                                          input logic avail);
    if (avail && (bank == rd_ptr)) return BANK_RD;
    if (!full && (bank == wr_ptr)) return BANK_WR;
    return BANK_IDLE;
  endfunction

endpackage

// File: rtl/pytxacl_ringbuf_ctrl_if.sv
// bsm/lnctrl access bundle for the ring buffer, plus a debug view of pointers and count.
interface pytxacl_ringbuf_ctrl_if #(
  parameter int DW    = pytxacl_pkg::DEF_DW,
  parameter int AW    = pytxacl_pkg::DEF_AW,
  parameter int NBANK = pytxacl_pkg::DEF_NBANK,
  parameter int LW    = pytxacl_pkg::DEF_LW
);
  localparam int PTRW = $clog2(NBANK);

  // Strobe semantics: bsm_cs/bsm_we/bsm_commit take effect only while !bsm_full
  // (a commit on a full ring is also accepted if a legal tx_ack frees a slot in
  // the same cycle); lnctrl_cs and tx_ack take effect only while lnctrl_avail;
  // flush overrides commit and ack in its cycle. Pulses are one cycle wide.
  logic            bsm_cs;
  logic            bsm_we;
  logic [AW-1:0]   bsm_addr;
  logic [DW-1:0]   bsm_din;
  logic            bsm_commit;
  logic [LW-1:0]   bsm_len;
  logic            bsm_full;
  logic            lnctrl_cs;
  logic [AW-1:0]   lnctrl_addr;
  logic [DW-1:0]   lnctrl_dout;
  logic            lnctrl_avail;
  logic [LW-1:0]   lnctrl_len;
  logic            txacl_seqn;
  logic            tx_ack;
  logic            flush;
  logic            ovf_err;
  logic [PTRW-1:0] dbg_wr_ptr;
  logic [PTRW-1:0] dbg_rd_ptr;
  logic [PTRW:0]   dbg_count;

  modport master (
    output bsm_cs, bsm_we, bsm_addr, bsm_din, bsm_commit, bsm_len,
           lnctrl_cs, lnctrl_addr, tx_ack, flush,
    input  bsm_full, lnctrl_dout, lnctrl_avail, lnctrl_len, txacl_seqn,
           ovf_err, dbg_wr_ptr, dbg_rd_ptr, dbg_count
  );

  modport slave (
    input  bsm_cs, bsm_we, bsm_addr, bsm_din, bsm_commit, bsm_len,
           lnctrl_cs, lnctrl_addr, tx_ack, flush,
    output bsm_full, lnctrl_dout, lnctrl_avail, lnctrl_len, txacl_seqn,
           ovf_err, dbg_wr_ptr, dbg_rd_ptr, dbg_count
  );

endinterface

// File: rtl/pytxacl_ringbuf_ctrl_sram_1p.sv
// Generic single-port synchronous RAM; read data appears the cycle after CS.
module sram_1p #(
  parameter int DW = 32,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          cs,
  input  logic          we,
  input  logic [AW-1:0] a,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout
);

  logic [DW-1:0] mem [2**AW];

  // Output holds across writes and idle cycles, like a typical macro.
  always_ff @(posedge clk) begin
    if (cs) begin
      if (we) mem[a] <= din;
      else    dout   <= mem[a];
    end
  end

endmodule

// File: rtl/pytxacl_ringbuf_ctrl.sv
// ACL TX payload ring: NBANK SRAM banks queued as packets between bsm (writer) and lnctrl (reader).
module pytxacl_ringbuf_ctrl #(
  parameter int DW    = pytxacl_pkg::DEF_DW,
  parameter int AW    = pytxacl_pkg::DEF_AW,
  parameter int NBANK = pytxacl_pkg::DEF_NBANK,
  parameter int LW    = pytxacl_pkg::DEF_LW
) (
  input  logic                   clk_6M,
  input  logic                   rstz,
  pytxacl_ringbuf_ctrl_if.slave  bus
);
  import pytxacl_pkg::*;

  localparam int            PTRW     = $clog2(NBANK);
  localparam logic [PTRW:0] FULL_CNT = (PTRW+1)'(NBANK);

  logic [PTRW-1:0] wr_ptr;
  logic [PTRW-1:0] rd_ptr;
  logic [PTRW-1:0] rd_ptr_d1;
  logic [PTRW:0]   count;
  logic [LW-1:0]   len_q [NBANK];
  logic            seqn;
  logic            ovf;
  logic            rd_cs_d1;
  logic [DW-1:0]   dout_q;
  logic [DW-1:0]   bank_dout [NBANK];

  logic full;
  logic avail;
  logic ack_ok;
  logic commit_ok;
  logic rd_cs;

  assign full      = (count == FULL_CNT);
  assign avail     = (count != '0);
  assign ack_ok    = bus.tx_ack & avail;
  assign commit_ok = bus.bsm_commit & (~full | ack_ok);
  assign rd_cs     = bus.lnctrl_cs & avail;

  always_ff @(posedge clk_6M or negedge rstz) begin
    if (!rstz) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      seqn   <= 1'b0;
      ovf    <= 1'b0;
      for (int i = 0; i < NBANK; i++) len_q[i] <= '0;
    end else if (bus.flush) begin
      // Drop the queue in place; the read bank and SEQN stay where they are.
      wr_ptr <= rd_ptr;
      count  <= '0;
    end else begin
      if (commit_ok) begin
        len_q[wr_ptr] <= bus.bsm_len;
        wr_ptr        <= wr_ptr + PTRW'(1);
      end
      if (ack_ok) begin
        rd_ptr <= rd_ptr + PTRW'(1);
        seqn   <= ~seqn;
      end
      if (bus.bsm_commit && !commit_ok) ovf <= 1'b1;
      case ({commit_ok, ack_ok})
        2'b10:   count <= count + (PTRW+1)'(1);
        2'b01:   count <= count - (PTRW+1)'(1);
        default: ;
      endcase
    end
  end

  // Read pipeline: bank latches at edge N, dout register captures at edge N+1.
  always_ff @(posedge clk_6M or negedge rstz) begin
    if (!rstz) begin
      rd_cs_d1  <= 1'b0;
      rd_ptr_d1 <= '0;
      dout_q    <= '0;
    end else begin
      rd_cs_d1  <= rd_cs;
      rd_ptr_d1 <= rd_ptr;
      if (rd_cs_d1) dout_q <= bank_dout[rd_ptr_d1];
    end
  end

  for (genvar g = 0; g < NBANK; g++) begin : g_bank
    bank_role_e    role;
    logic          cs;
    logic          we;
    logic [AW-1:0] a;
    logic [DW-1:0] din;

    always_comb begin
      role = bank_sel(g, int'(wr_ptr), int'(rd_ptr), full, avail);
      cs   = 1'b0;
      we   = 1'b0;
      a    = '0;
      din  = '0;
      unique case (role)
        BANK_WR: begin
          cs  = bus.bsm_cs;
          we  = bus.bsm_we;
          a   = bus.bsm_addr;
          din = bus.bsm_din;
        end
        BANK_RD: begin
          cs = bus.lnctrl_cs;
          a  = bus.lnctrl_addr;
        end
        default: ;
      endcase
    end

    sram_1p #(.DW(DW), .AW(AW)) u_sram (
      .clk  (clk_6M),
      .cs   (cs),
      .we   (we),
      .a    (a),
      .din  (din),
      .dout (bank_dout[g])
    );
  end

  assign bus.bsm_full     = full;
  assign bus.lnctrl_avail = avail;
  assign bus.lnctrl_len   = len_q[rd_ptr];
  assign bus.lnctrl_dout  = dout_q;
  assign bus.txacl_seqn   = seqn;
  assign bus.ovf_err      = ovf;
  assign bus.dbg_wr_ptr   = wr_ptr;
  assign bus.dbg_rd_ptr   = rd_ptr;
  assign bus.dbg_count    = count;

endmodule

// File: tb/tb_pytxacl_ringbuf_ctrl.sv
// Bench for pytxacl_ringbuf_ctrl: directed sequences, a control vector table and a randomized run.
module tb_pytxacl_ringbuf_ctrl;
  localparam int NBANK = 4;
  localparam int RA    = 8;

  logic clk_6M = 1'b0;
  logic rstz   = 1'b0;
  always #5 clk_6M = ~clk_6M;

  pytxacl_ringbuf_ctrl_if bus ();
  pytxacl_ringbuf_ctrl dut (.clk_6M(clk_6M), .rstz(rstz), .bus(bus));

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  logic [31:0] exp_q[$];
  int          due_q[$];

  typedef struct {
    logic       commit;
    logic [9:0] len;
    logic       ack;
    logic       flush;
    int         e_count;
    int         e_wr;
    int         e_rd;
    logic       e_full;
    logic       e_avail;
    int         e_len;
    logic       e_seqn;
    logic       e_ovf;
  } vec_t;
  vec_t tbl[13];

  // Reference model state (random phase)
  int          m_count, m_rd, m_len[NBANK];
  logic        m_seqn, m_ovf;
  logic [31:0] m_mem[NBANK][RA];
  bit          m_wr[NBANK][RA];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got 0x%08h, want 0x%08h", name, cyc, act, exp);
    end
  endtask

  task automatic idle();
    bus.bsm_cs = 0; bus.bsm_we = 0; bus.bsm_addr = '0; bus.bsm_din = '0;
    bus.bsm_commit = 0; bus.bsm_len = '0; bus.lnctrl_cs = 0; bus.lnctrl_addr = '0;
    bus.tx_ack = 0; bus.flush = 0;
  endtask

  task automatic tick();
    @(posedge clk_6M);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    idle();
    rstz = 1'b0;
    repeat (2) tick();
    rstz = 1'b1;
  endtask

  task automatic chk_ctl(input string tag, input int cnt, input int wr, input int rd,
                         input logic full, input logic avail, input int len,
                         input logic seqn, input logic ovf);
    chk({tag, ".count"}, 32'(bus.dbg_count), cnt);
    chk({tag, ".wr_ptr"}, 32'(bus.dbg_wr_ptr), wr);
    chk({tag, ".rd_ptr"}, 32'(bus.dbg_rd_ptr), rd);
    chk({tag, ".full"}, 32'(bus.bsm_full), 32'(full));
    chk({tag, ".avail"}, 32'(bus.lnctrl_avail), 32'(avail));
    chk({tag, ".len"}, 32'(bus.lnctrl_len), len);
    chk({tag, ".seqn"}, 32'(bus.txacl_seqn), 32'(seqn));
    chk({tag, ".ovf"}, 32'(bus.ovf_err), 32'(ovf));
  endtask

  task automatic bsm_write(input logic [7:0] addr, input logic [31:0] data);
    bus.bsm_cs = 1; bus.bsm_we = 1; bus.bsm_addr = addr; bus.bsm_din = data;
    tick();
    bus.bsm_cs = 0; bus.bsm_we = 0;
  endtask

  task automatic bsm_commit(input logic [9:0] len);
    bus.bsm_commit = 1; bus.bsm_len = len;
    tick();
    bus.bsm_commit = 0;
  endtask

  task automatic ack();
    bus.tx_ack = 1;
    tick();
    bus.tx_ack = 0;
  endtask

  initial begin
    tbl[0]  = '{1, 27, 0, 0, 1, 1, 0, 0, 1, 27, 0, 0};
    tbl[1]  = '{1, 54, 0, 0, 2, 2, 0, 0, 1, 27, 0, 0};
    tbl[2]  = '{0,  0, 1, 0, 1, 2, 1, 0, 1, 54, 1, 0};
    tbl[3]  = '{0,  0, 1, 0, 0, 2, 2, 0, 0,  0, 0, 0};
    tbl[4]  = '{0,  0, 1, 0, 0, 2, 2, 0, 0,  0, 0, 0};
    tbl[5]  = '{1, 10, 0, 0, 1, 3, 2, 0, 1, 10, 0, 0};
    tbl[6]  = '{1, 11, 0, 0, 2, 0, 2, 0, 1, 10, 0, 0};
    tbl[7]  = '{1, 12, 0, 0, 3, 1, 2, 0, 1, 10, 0, 0};
    tbl[8]  = '{1, 13, 0, 0, 4, 2, 2, 1, 1, 10, 0, 0};
    tbl[9]  = '{1, 14, 1, 0, 4, 3, 3, 1, 1, 11, 1, 0};
    tbl[10] = '{1, 15, 0, 0, 4, 3, 3, 1, 1, 11, 1, 1};
    tbl[11] = '{1, 16, 0, 1, 0, 3, 3, 0, 0, 11, 1, 1};
    tbl[12] = '{0,  0, 1, 0, 0, 3, 3, 0, 0, 11, 1, 1};

    // Reset state and first packet: write, commit, read latency
    do_reset();
    chk_ctl("reset", 0, 0, 0, 0, 0, 0, 0, 0);
    chk("reset.dout", bus.lnctrl_dout, 32'h0);
    for (int i = 0; i < 4; i++) bsm_write(8'(i), 32'hA5A5_0000 + 32'(i));
    bsm_commit(10'd16);
    chk_ctl("pkt1", 1, 1, 0, 0, 1, 16, 0, 0);
    bus.lnctrl_cs = 1; bus.lnctrl_addr = 8'd2;
    tick();
    bus.lnctrl_cs = 0;
    chk("pkt1.dout_n1", bus.lnctrl_dout, 32'h0);
    tick();
    chk("pkt1.dout_n2", bus.lnctrl_dout, 32'hA5A5_0002);
    tick();
    chk("pkt1.dout_hold", bus.lnctrl_dout, 32'hA5A5_0002);

    // Control vector table: ack sequencing, full+commit+ack, overflow, flush
    do_reset();
    for (int v = 0; v < 13; v++) begin
      bus.bsm_commit = tbl[v].commit; bus.bsm_len = tbl[v].len;
      bus.tx_ack = tbl[v].ack; bus.flush = tbl[v].flush;
      tick();
      idle();
      chk_ctl($sformatf("tbl%0d", v), tbl[v].e_count, tbl[v].e_wr, tbl[v].e_rd,
              tbl[v].e_full, tbl[v].e_avail, tbl[v].e_len, tbl[v].e_seqn, tbl[v].e_ovf);
    end

    // Fill, overflow, blocked write, then drain checking each bank's word 0
    do_reset();
    for (int p = 0; p < 4; p++) begin
      bsm_write(8'd0, 32'hB0 + 32'(p));
      bsm_commit(10'(p + 1));
    end
    chk("full.full", 32'(bus.bsm_full), 32'd1);
    chk("full.count", 32'(bus.dbg_count), 32'd4);
    bsm_commit(10'd99);
    chk("ovf.ovf", 32'(bus.ovf_err), 32'd1);
    chk("ovf.count", 32'(bus.dbg_count), 32'd4);
    chk("ovf.len", 32'(bus.lnctrl_len), 32'd1);
    bsm_write(8'd0, 32'hDEAD_BEEF);
    for (int p = 0; p < 4; p++) begin
      bus.lnctrl_cs = 1; bus.lnctrl_addr = 8'd0;
      tick();
      bus.lnctrl_cs = 0;
      tick();
      chk($sformatf("drain%0d.dout", p), bus.lnctrl_dout, 32'hB0 + 32'(p));
      ack();
    end
    chk("drain.avail", 32'(bus.lnctrl_avail), 32'd0);

    // Asynchronous reset in the middle of a write, away from any clock edge
    bsm_commit(10'd9);
    ack();
    bsm_commit(10'd7);
    chk_ctl("pre_rst", 1, 2, 1, 0, 1, 7, 1, 1);
    bus.bsm_cs = 1; bus.bsm_we = 1; bus.bsm_addr = 8'd3; bus.bsm_din = 32'h1234_5678;
    #2;
    rstz = 1'b0;
    #1;
    chk_ctl("async_rst", 0, 0, 0, 0, 0, 0, 0, 0);
    chk("async_rst.dout", bus.lnctrl_dout, 32'h0);
    idle();
    tick();
    rstz = 1'b1;

    // Randomized traffic against a queue-level model
    do_reset();
    m_count = 0; m_rd = 0; m_seqn = 0; m_ovf = 0;
    for (int b = 0; b < NBANK; b++) begin
      m_len[b] = 0;
      for (int a = 0; a < RA; a++) m_wr[b][a] = 0;
    end
    for (int it = 0; it < 3000; it++) begin
      logic        rd_now, rd_ok, full_m, avail_m, ack_ok, com_ok;
      logic [31:0] rd_data;
      int          wr_idx;
      bus.bsm_cs      = ($urandom_range(0, 1) == 1);
      bus.bsm_we      = ($urandom_range(0, 3) != 0);
      bus.bsm_addr    = 8'($urandom_range(0, RA - 1));
      bus.bsm_din     = $urandom;
      bus.bsm_commit  = ($urandom_range(0, 9) < 3);
      bus.bsm_len     = 10'($urandom);
      bus.lnctrl_cs   = ($urandom_range(0, 9) < 4);
      bus.lnctrl_addr = 8'($urandom_range(0, RA - 1));
      bus.tx_ack      = ($urandom_range(0, 9) < 3);
      bus.flush       = ($urandom_range(0, 99) < 3);

      full_m  = (m_count == NBANK);
      avail_m = (m_count != 0);
      wr_idx  = (m_rd + m_count) % NBANK;
      rd_now  = bus.lnctrl_cs && avail_m;
      rd_ok   = m_wr[m_rd][bus.lnctrl_addr];
      rd_data = m_mem[m_rd][bus.lnctrl_addr];
      if (bus.bsm_cs && bus.bsm_we && !full_m) begin
        m_mem[wr_idx][bus.bsm_addr] = bus.bsm_din;
        m_wr[wr_idx][bus.bsm_addr]  = 1;
      end
      if (bus.flush) begin
        m_count = 0;
      end else begin
        ack_ok = bus.tx_ack && avail_m;
        com_ok = bus.bsm_commit && (!full_m || ack_ok);
        if (bus.bsm_commit && !com_ok) m_ovf = 1;
        if (com_ok) begin
          m_len[wr_idx] = int'(bus.bsm_len);
          m_count++;
        end
        if (ack_ok) begin
          m_rd = (m_rd + 1) % NBANK;
          m_count--;
          m_seqn = ~m_seqn;
        end
      end

      tick();
      if (due_q.size() != 0 && due_q[0] == cyc) begin
        chk("rnd.dout", bus.lnctrl_dout, exp_q.pop_front());
        void'(due_q.pop_front());
      end
      if (rd_now && rd_ok) begin
        exp_q.push_back(rd_data);
        due_q.push_back(cyc + 1);
      end
      chk_ctl("rnd", m_count, (m_rd + m_count) % NBANK, m_rd, (m_count == NBANK),
              (m_count != 0), m_len[m_rd], m_seqn, m_ovf);
    end
    idle();
    tick();
    if (due_q.size() != 0 && due_q[0] == cyc) begin
      chk("rnd.dout_tail", bus.lnctrl_dout, exp_q.pop_front());
      void'(due_q.pop_front());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
